// File: rtl/alu8bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu8bit_pkg
// Description : Opcodes, FSM state encoding and opcode-class helpers shared by
//               the ALU issue/writeback stage and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package alu8bit_pkg;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_INC = 4'b1101;
    localparam logic [3:0] OP_DEC = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Opcodes with bit 2 clear are reserved; the ALU leaves its carry stale.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op & 4'b0100) != 4'b0000;
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op & 4'b1000) != 4'b0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu8bit_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu8bit_regfile
// Description : NREG x 8 register file, async clear, two combinational read
//               ports, writeback and load write ports (writeback has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module alu8bit_regfile
    import alu8bit_pkg::*;
#(
    parameter  int NREG = 4,
    localparam int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rd_addr_a,
    input  logic [RA_W-1:0] rd_addr_b,
    output logic [7:0]      rd_data_a,
    output logic [7:0]      rd_data_b,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [7:0]      wb_data,
    input  logic            ld_en,
    input  logic [RA_W-1:0] ld_addr,
    input  logic [7:0]      ld_data
);

    logic [7:0] w_mem [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [7:0] r_q;
            logic       w_wb_hit;
            logic       w_ld_hit;

            assign w_wb_hit = wb_en && (wb_addr == RA_W'(gi));
            assign w_ld_hit = ld_en && (ld_addr == RA_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_wb_hit) begin
                    r_q <= wb_data;
                end else if (w_ld_hit) begin
                    r_q <= ld_data;
                end
            end

            assign w_mem[gi] = r_q;
        end
    endgenerate

    assign rd_data_a = w_mem[rd_addr_a];
    assign rd_data_b = w_mem[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu8bit_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu8bit_issue
// Description : Issue/writeback stage around an 8-bit combinational ALU; one
//               instruction every 3 cycles (accept, execute, writeback).
//               Optional macro ALU_ISSUE_PERF_CNT_EN adds a retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu8bit_issue
    import alu8bit_pkg::*;
#(
    parameter  int NREG = 4,
    localparam int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic [RA_W-1:0] instr_rd,
    input  logic [RA_W-1:0] instr_rs1,
    input  logic [RA_W-1:0] instr_rs2,
    input  logic            load_en,
    input  logic [RA_W-1:0] load_addr,
    input  logic [7:0]      load_data,
    output logic            alu_en,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic [7:0]      alu_out,
    input  logic            alu_cout,
    output logic            res_valid,
    output logic [7:0]      res_data,
    output logic            carry_flag,
    output logic            zero_flag
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;

    logic            r_alu_en;
    logic [3:0]      r_alu_op;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [RA_W-1:0] r_rd;
    logic            r_res_valid;
    logic [7:0]      r_res_data;
    logic            r_carry;
    logic            r_zero;

    logic [7:0]      w_rs1_data;
    logic [7:0]      w_rs2_data;
    logic [7:0]      w_result;
    logic            w_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (instr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC:    w_next_state = WB;
            WB:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Reserved opcodes produce zero; logic opcodes never report a carry.
    always_comb begin
        w_result = 8'h00;
        w_cout   = 1'b0;
        if (op_is_legal(r_alu_op)) begin
            w_result = alu_out;
            w_cout   = op_is_arith(r_alu_op) ? alu_cout : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_en    <= 1'b0;
            r_alu_op    <= 4'h0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_rd        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_en <= 1'b1;
                r_alu_op <= instr_op;
                r_alu_a  <= w_rs1_data;
                r_alu_b  <= w_rs2_data;
                r_rd     <= instr_rd;
            end else if (r_state == EXEC) begin
                r_alu_en <= 1'b0;
            end

            r_res_valid <= (r_state == EXEC);
            if (r_state == EXEC) begin
                r_res_data <= w_result;
                r_carry    <= w_cout;
                r_zero     <= (w_result == 8'h00);
            end
        end
    end

    alu8bit_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (instr_rs1),
        .rd_addr_b (instr_rs2),
        .rd_data_a (w_rs1_data),
        .rd_data_b (w_rs2_data),
        .wb_en     (r_res_valid),
        .wb_addr   (r_rd),
        .wb_data   (r_res_data),
        .ld_en     (load_en),
        .ld_addr   (load_addr),
        .ld_data   (load_data)
    );

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [15:0] r_retired_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt <= 16'h0000;
        end else if (r_res_valid && (r_retired_cnt != 16'hFFFF)) begin
            r_retired_cnt <= r_retired_cnt + 16'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

    assign instr_ready = (r_state == IDLE);
    assign alu_en      = r_alu_en;
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign carry_flag  = r_carry;
    assign zero_flag   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu8bit_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu8bit_issue
// Description : Self-checking bench for alu8bit_issue with a behavioural ALU
//               and a reference register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu8bit_issue;

    localparam int NREG = 4;
    localparam int RA_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [3:0]      instr_op = 4'h0;
    logic [RA_W-1:0] instr_rd = '0;
    logic [RA_W-1:0] instr_rs1 = '0;
    logic [RA_W-1:0] instr_rs2 = '0;
    logic            load_en = 1'b0;
    logic [RA_W-1:0] load_addr = '0;
    logic [7:0]      load_data = 8'h00;
    logic            alu_en;
    logic [3:0]      alu_op;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic [7:0]      alu_out;
    logic            alu_cout;
    logic            res_valid;
    logic [7:0]      res_data;
    logic            carry_flag;
    logic            zero_flag;

    logic [7:0]      junk_out  = 8'h00;
    logic            stale_cout = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_rf [NREG];

    alu8bit_issue #(.NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .alu_en      (alu_en),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    // Downstream ALU: logic ops and reserved codes leave a stale carry.
    always_comb begin
        logic [8:0] s;
        s = 9'h000;
        alu_out  = junk_out;
        alu_cout = stale_cout;
        case (alu_op)
            4'b1111: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = s[7:0]; alu_cout = s[8]; end
            4'b1110: begin s = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = s[7:0]; alu_cout = s[8]; end
            4'b1101: begin s = {1'b0, alu_a} + 9'd1;          alu_out = s[7:0]; alu_cout = s[8]; end
            4'b1100: begin s = {1'b0, alu_a} - 9'd1;          alu_out = s[7:0]; alu_cout = s[8]; end
            4'b0111: alu_out = alu_a & alu_b;
            4'b0110: alu_out = alu_a | alu_b;
            4'b0101: alu_out = alu_a ^ alu_b;
            4'b0100: alu_out = ~alu_a;
            default: ;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference semantics in plain integer arithmetic.
    task automatic ref_exec(input int op, input int a, input int b, output int res, output int c);
        res = 0;
        c   = 0;
        case (op)
            15: begin res = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            14: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            13: begin res = (a + 1) % 256;       c = (a == 255) ? 1 : 0; end
            12: begin res = (a + 255) % 256;     c = (a == 0) ? 1 : 0; end
            7:  res = a & b;
            6:  res = a | b;
            5:  res = a ^ b;
            4:  res = 255 - a;
            default: begin res = 0; c = 0; end
        endcase
    endtask

    task automatic do_load(input int addr, input int data);
        load_en   = 1'b1;
        load_addr = RA_W'(addr);
        load_data = 8'(data);
        tick();
        load_en = 1'b0;
        ref_rf[addr] = data;
    endtask

    // ld_cyc: 0 none, 1 load during EXEC, 2 load during WB
    task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                         input int ld_cyc, input int ld_a, input int ld_d);
        int a, b, res, c;
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        ref_exec(op, a, b, res, c);
        check("ready_idle", 16'(instr_ready), 16'd1);
        instr_valid = 1'b1;
        instr_op    = 4'(op);
        instr_rd    = RA_W'(rd);
        instr_rs1   = RA_W'(rs1);
        instr_rs2   = RA_W'(rs2);
        tick();
        instr_valid = 1'b0;
        check("exec_alu_en", 16'(alu_en), 16'd1);
        check("exec_alu_op", 16'(alu_op), 16'(op));
        check("exec_alu_a", 16'(alu_a), 16'(a));
        check("exec_alu_b", 16'(alu_b), 16'(b));
        check("exec_ready", 16'(instr_ready), 16'd0);
        check("exec_res_valid", 16'(res_valid), 16'd0);
        if (ld_cyc == 1) begin
            load_en = 1'b1; load_addr = RA_W'(ld_a); load_data = 8'(ld_d);
        end
        tick();
        load_en = 1'b0;
        if (ld_cyc == 1) ref_rf[ld_a] = ld_d;
        check("wb_res_valid", 16'(res_valid), 16'd1);
        check("wb_res_data", 16'(res_data), 16'(res));
        check("wb_carry", 16'(carry_flag), 16'(c));
        check("wb_zero", 16'(zero_flag), (res == 0) ? 16'd1 : 16'd0);
        check("wb_alu_en", 16'(alu_en), 16'd0);
        check("wb_ready", 16'(instr_ready), 16'd0);
        if (ld_cyc == 2) begin
            load_en = 1'b1; load_addr = RA_W'(ld_a); load_data = 8'(ld_d);
        end
        tick();
        load_en = 1'b0;
        if (ld_cyc == 2) ref_rf[ld_a] = ld_d;
        ref_rf[rd] = res;
        check("post_res_valid", 16'(res_valid), 16'd0);
    endtask

    // Observe one register through alu_a with an OR that writes it back unchanged.
    task automatic peek(input int r);
        issue(6, r, r, r, 0, 0, 0);
    endtask

    initial begin
        int op, rd, rs1, rs2, res_a, c_a, res_b, c_b, a2, b2;
        for (int i = 0; i < NREG; i++) ref_rf[i] = 0;

        #2;
        check("rst_ready", 16'(instr_ready), 16'd1);
        check("rst_res_valid", 16'(res_valid), 16'd0);
        check("rst_alu_en", 16'(alu_en), 16'd0);
        check("rst_alu_a", 16'(alu_a), 16'd0);
        check("rst_res_data", 16'(res_data), 16'd0);
        check("rst_flags", {14'd0, carry_flag, zero_flag}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // ADD with carry out
        do_load(0, 8'hF0);
        do_load(1, 8'h20);
        issue(15, 2, 0, 1, 0, 0, 0);
        peek(2);

        // AND to zero while the ALU reports a stale carry
        stale_cout = 1'b1;
        do_load(3, 8'h0F);
        issue(7, 1, 0, 3, 0, 0, 0);

        // Reserved opcode with garbage ALU outputs
        junk_out = 8'hAA;
        issue(4'b1011, 3, 0, 1, 0, 0, 0);
        peek(3);
        stale_cout = 1'b0;

        // Back-to-back with instr_valid held high
        do_load(1, 8'h20);
        ref_exec(15, ref_rf[0], ref_rf[1], res_a, c_a);
        instr_valid = 1'b1; instr_op = 4'hF; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        tick();
        instr_op = 4'hE; instr_rd = 2'd3; instr_rs1 = 2'd2; instr_rs2 = 2'd1;
        check("b2b_ready_c1", 16'(instr_ready), 16'd0);
        tick();
        check("b2b_ready_c2", 16'(instr_ready), 16'd0);
        check("b2b_pulse1", 16'(res_valid), 16'd1);
        check("b2b_data1", 16'(res_data), 16'(res_a));
        tick();
        ref_rf[2] = res_a;
        check("b2b_ready_c3", 16'(instr_ready), 16'd1);
        check("b2b_no_pulse_c3", 16'(res_valid), 16'd0);
        a2 = ref_rf[2]; b2 = ref_rf[1];
        ref_exec(14, a2, b2, res_b, c_b);
        tick();
        instr_valid = 1'b0;
        check("b2b_accept2_en", 16'(alu_en), 16'd1);
        check("b2b_accept2_a", 16'(alu_a), 16'(a2));
        check("b2b_no_pulse_c4", 16'(res_valid), 16'd0);
        tick();
        check("b2b_pulse2", 16'(res_valid), 16'd1);
        check("b2b_data2", 16'(res_data), 16'(res_b));
        check("b2b_carry2", 16'(carry_flag), 16'(c_b));
        tick();
        ref_rf[3] = res_b;
        check("b2b_end", 16'(res_valid), 16'd0);

        // Load colliding with writeback: same address, then different address
        do_load(0, 8'hF0);
        do_load(1, 8'h20);
        issue(15, 2, 0, 1, 2, 2, 8'h55);
        peek(2);
        issue(15, 2, 0, 1, 2, 1, 8'h55);
        peek(1);
        peek(2);

        // Load to a source register while the instruction is in flight
        issue(15, 3, 1, 0, 1, 1, 8'h01);
        peek(1);
        peek(3);

        // Reset during EXEC
        issue(15, 2, 0, 0, 0, 0, 0);
        instr_valid = 1'b1; instr_op = 4'hF; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
        tick();
        instr_valid = 1'b0;
        check("mid_alu_en", 16'(alu_en), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_alu_en", 16'(alu_en), 16'd0);
        check("mid_rst_flags", {14'd0, carry_flag, zero_flag}, 16'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) ref_rf[i] = 0;
        check("mid_rst_no_pulse", 16'(res_valid), 16'd0);
        tick();
        check("mid_rel_ready", 16'(instr_ready), 16'd1);
        check("mid_rel_no_pulse", 16'(res_valid), 16'd0);
        check("mid_rel_flags", {14'd0, carry_flag, zero_flag}, 16'd0);
        for (int i = 0; i < NREG; i++) peek(i);
        do_load(0, 8'h7F);
        issue(13, 1, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, NREG - 1), $urandom_range(0, 255));
            junk_out   = 8'($urandom);
            stale_cout = 1'($urandom);
            op  = $urandom_range(0, 15);
            rd  = $urandom_range(0, NREG - 1);
            rs1 = $urandom_range(0, NREG - 1);
            rs2 = $urandom_range(0, NREG - 1);
            issue(op, rd, rs1, rs2, $urandom_range(0, 2), $urandom_range(0, NREG - 1), $urandom_range(0, 255));
        end
        for (int i = 0; i < NREG; i++) peek(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu8bit_issue.md
Name: alu8bit_issue

Overview:
- Issue/writeback stage directly upstream and downstream of the 8-bit combinational ALU.
- Accepts register-addressed instructions through a valid/ready handshake and reads operands from a small internal register file.
- Drives registered opcode/operand inputs to the ALU, then captures its result and carry.
- Writes the result back to the register file and updates carry/zero flags; one instruction completes every 3 cycles.

Parameters:
- NREG, 4, number of 8-bit registers; power of two, at least 2. Register address width RA_W = clog2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  stage can accept; high only in IDLE
- instr_op  in  4  ALU opcode
- instr_rd  in  RA_W  destination register
- instr_rs1  in  RA_W  operand A register
- instr_rs2  in  RA_W  operand B register
- load_en  in  1  external register-file write
- load_addr  in  RA_W  external write address
- load_data  in  8  external write data
- alu_en  out  1  high while an operation is presented to the ALU
- alu_op  out  4  opcode to the ALU
- alu_a  out  8  operand A to the ALU
- alu_b  out  8  operand B to the ALU
- alu_out  in  8  ALU result
- alu_cout  in  1  ALU carry
- res_valid  out  1  one-cycle pulse on writeback
- res_data  out  8  written-back value
- carry_flag  out  1  sticky until the next writeback
- zero_flag  out  1  sticky until the next writeback

Behaviour:
- Reset (async): state=IDLE; all register-file entries, alu_en, alu_op, alu_a, alu_b, res_valid, res_data and both flags = 0. instr_ready = (state==IDLE), so it is 1 during and after reset.
- FSM: IDLE -> EXEC -> WB -> IDLE.
- IDLE: on instr_valid && instr_ready (cycle 0), latch op, rd, and the RF values of rs1/rs2 at that edge. Go to EXEC.
- EXEC (cycle 1): alu_en=1; alu_op/alu_a/alu_b hold the latched values. At the end of the cycle, sample alu_out/alu_cout into the result register.
- WB (cycle 2): RF[rd] <= result; res_valid=1; res_data=result; carry_flag and zero_flag update. Go to IDLE.
- Outside EXEC: alu_en=0, and alu_op/a/b keep their last values.
- Opcode legality: legal opcodes are 1111 add, 1110 sub, 1101 inc, 1100 dec, 0111 and, 0110 or, 0101 xor, 0100 not.
  - Any opcode with op[2]==0 is reserved. It still executes and writes back, but the block forces result=0 and cout=0, ignoring alu_cout, because the ALU leaves cout stale for these codes.
- Carry: for logic opcodes (op[3]==0), the captured cout is forced to 0. For arithmetic opcodes, alu_cout is captured unaltered.
- Zero flag: zero_flag = (result==0).
- Operand rules: inc, dec and not use only alu_a. alu_b still carries RF[rs2].
- rs1==rs2 is permitted. rd may equal rs1 or rs2; operands were captured at accept, so there is no hazard.
- Load port: active in every state. RF[load_addr] <= load_data on the next edge.
  - A load to a source register after accept does not affect the in-flight instruction.
  - Simultaneous load and WB to the same address: the WB value wins. Different addresses: both write.
- Back-pressure: instr_valid held high while busy is not consumed. The next accept happens in the first IDLE cycle, i.e. cycle 3 relative to the prior accept.
- Reset mid-operation: the in-flight instruction is discarded. No res_valid pulse; the RF is cleared.

Optional Feature:
- ALU_ISSUE_PERF_CNT_EN defined: adds output port retired_cnt (16 bits), reset 0.
  - Increments on every res_valid and saturates at 0xFFFF.
  - Reserved opcodes count as retired.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu8bit_pkg holds:
  - opcode localparams OP_ADD=4'b1111, OP_SUB=4'b1110, OP_INC=4'b1101, OP_DEC=4'b1100, OP_AND=4'b0111, OP_OR=4'b0110, OP_XOR=4'b0101, OP_NOT=4'b0100;
  - state encoding IDLE/EXEC/WB;
  - function op_is_legal(op) = op[2];
  - function op_is_arith(op) = op[3].
- One sub-module, alu8bit_regfile: NREG x 8 register file with async clear, two combinational read ports and two write ports, using the WB-over-load priority rule above.

Test Plan:
- Load r0=0xF0, r1=0x20; issue ADD rd=2 rs1=0 rs2=1, with the ALU model returning 0x10/cout=1 -> alu_a=0xF0, alu_b=0x20 in cycle 1; res_valid in cycle 2 with res_data=0x10; carry_flag=1, zero_flag=0; RF[2]=0x10.
- Load r0=0xF0, r3=0x0F; issue AND rd=1 rs1=0 rs2=3, with the ALU returning 0x00 and alu_cout forced to 1 -> res_data=0x00, carry_flag=0, zero_flag=1.
- Issue reserved op 4'b1011, with the ALU driving alu_out=0xAA and alu_cout=1 -> res_data=0x00, carry_flag=0, zero_flag=1; RF[rd]=0x00.
- Hold instr_valid high for two back-to-back instructions -> instr_ready=0 in cycles 1-2; second instruction accepted in cycle 3; exactly two res_valid pulses, 3 cycles apart.
- During WB to rd=2 (result 0x10), also drive load_en with addr=2, data=0x55 -> RF[2]=0x10. Repeat with load addr=1 -> RF[1]=0x55 and RF[2]=0x10.
- Assert rst during EXEC -> no res_valid; all RF entries=0; flags=0; instr_ready=1 the cycle after release; a new instruction is accepted normally.
